// File: rtl/larpix_readout_pkg.sv
// Shared constants and types for the ADC readout arbiter.
package larpix_readout_pkg;

  localparam int NUMCHANNELS = 64;
  localparam int ADCBITS     = 10;
  localparam int TS_W        = 24;
  localparam int CHAN_ID_W   = 6;
  localparam int FIFO_W      = CHAN_ID_W + ADCBITS + TS_W;

  // Arbiter sequencing: pick a channel, push its word, give the channel a cycle to drop done.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  // Layout of one word pushed into the shared FIFO (MSB first).
  typedef struct packed {
    logic [CHAN_ID_W-1:0] chan_id;
    logic [ADCBITS-1:0]   adc;
    logic [TS_W-1:0]      ts;
  } fifo_word_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin search: first set request strictly after last_grant, wrapping to 0.
module rr_priority_encoder #(
  parameter int N     = 64,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  // Scan N positions starting one above the previous winner; the first hit wins.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_grant) + k) % N);
      if (!valid && req[idx]) begin
        grant_idx = idx;
        valid     = 1'b1;
      end else begin
        grant_idx = grant_idx;
      end
    end
  end

endmodule

// File: rtl/adc_readout_arbiter.sv
// Round-robin arbiter moving per-channel ADC words into one shared FIFO.
// Words are captured when a channel is selected and written unchanged later,
// so input changes during the write handshake cannot disturb a pending word.
module adc_readout_arbiter #(
  parameter int NUMCHANNELS = larpix_readout_pkg::NUMCHANNELS,
  parameter int ADCBITS     = larpix_readout_pkg::ADCBITS,
  parameter int TS_W        = larpix_readout_pkg::TS_W
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic [NUMCHANNELS-1:0]                            done,
  input  logic [ADCBITS*NUMCHANNELS-1:0]                    dout,
  input  logic [NUMCHANNELS-1:0]                            channel_mask,
  input  logic [TS_W-1:0]                                   timestamp,
  input  logic                                              fifo_full,
  output logic                                              fifo_wr_en,
  output logic [larpix_readout_pkg::CHAN_ID_W+ADCBITS+TS_W-1:0] fifo_wr_data,
  output logic [NUMCHANNELS-1:0]                            ack,
  output logic [15:0]                                       stall_count
);

  import larpix_readout_pkg::*;

  localparam int IDX_W = $clog2(NUMCHANNELS);
  localparam int DW    = CHAN_ID_W + ADCBITS + TS_W;

  arb_state_e              state_r;
  arb_state_e              state_next_s;
  logic [NUMCHANNELS-1:0]  eligible_s;
  logic [IDX_W-1:0]        rr_idx_s;
  logic                    rr_valid_s;
  logic                    capture_s;
  logic                    write_s;
  logic                    stall_inc_s;
  logic [IDX_W-1:0]        grant_r;
  logic [IDX_W-1:0]        last_grant_r;
  logic [ADCBITS-1:0]      adc_r;
  logic [TS_W-1:0]         ts_r;
  logic                    fifo_wr_en_r;
  logic [DW-1:0]           fifo_wr_data_r;
  logic [NUMCHANNELS-1:0]  ack_r;
  logic [15:0]             stall_r;

  assign eligible_s = done & ~channel_mask;

  rr_priority_encoder #(
    .N     (NUMCHANNELS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (eligible_s),
    .last_grant (last_grant_r),
    .grant_idx  (rr_idx_s),
    .valid      (rr_valid_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    write_s      = 1'b0;
    stall_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rr_valid_s) begin
          capture_s    = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!fifo_full) begin
          write_s      = 1'b1;
          state_next_s = ST_ACK;
        end else begin
          stall_inc_s  = 1'b1;
          state_next_s = ST_ISSUE;
        end
      end
      ST_ACK: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Capture the selected channel's word and drive the registered write/ack outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r        <= '0;
      last_grant_r   <= IDX_W'(NUMCHANNELS - 1);
      adc_r          <= '0;
      ts_r           <= '0;
      fifo_wr_en_r   <= 1'b0;
      fifo_wr_data_r <= '0;
      ack_r          <= '0;
    end else begin
      if (capture_s) begin
        grant_r <= rr_idx_s;
        adc_r   <= dout[int'(rr_idx_s)*ADCBITS +: ADCBITS];
        ts_r    <= timestamp;
      end
      fifo_wr_en_r <= write_s;
      ack_r        <= write_s ? ({{(NUMCHANNELS-1){1'b0}}, 1'b1} << grant_r) : '0;
      if (write_s) begin
        fifo_wr_data_r <= {CHAN_ID_W'(grant_r), adc_r, ts_r};
        last_grant_r   <= grant_r;
      end
    end
  end

  // Saturating count of cycles a captured word waited on a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_r <= 16'd0;
    end else if (stall_inc_s && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_wr_data = fifo_wr_data_r;
  assign ack          = ack_r;
  assign stall_count  = stall_r;

endmodule

// File: tb/tb_adc_readout_arbiter.sv
// Randomized + directed bench for adc_readout_arbiter with a transaction-level reference model.
module tb_adc_readout_arbiter;
  import larpix_readout_pkg::*;

  localparam int N  = NUMCHANNELS;
  localparam int DW = CHAN_ID_W + ADCBITS + TS_W;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N-1:0]         done = '0;
  logic [ADCBITS*N-1:0] dout = '0;
  logic [N-1:0]         channel_mask = '0;
  logic [TS_W-1:0]      timestamp = '0;
  logic                 fifo_full = 1'b0;
  logic                 fifo_wr_en;
  logic [DW-1:0]        fifo_wr_data;
  logic [N-1:0]         ack;
  logic [15:0]          stall_count;

  adc_readout_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .done         (done),
    .dout         (dout),
    .channel_mask (channel_mask),
    .timestamp    (timestamp),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .ack          (ack),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a captured word waiting for FIFO room, plus a mandatory
  // quiet cycle after each write before the next selection.
  bit         m_pending;
  int         m_ch;
  fifo_word_t m_word;
  bit         m_quiet;
  int         m_last;
  int         m_stall;
  bit         m_wr;
  logic [N-1:0] m_ack;
  fifo_word_t m_data;

  bit auto_clear = 1'b1;
  int cyc = 0;
  int wlog_ch[$];
  int wlog_cyc[$];

  task automatic model_reset();
    m_pending = 1'b0; m_ch = 0; m_word = '0; m_quiet = 1'b0;
    m_last = N - 1; m_stall = 0; m_wr = 1'b0; m_ack = '0; m_data = '0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else begin
      m_wr  = 1'b0;
      m_ack = '0;
      if (m_pending) begin
        if (!fifo_full) begin
          m_wr = 1'b1; m_ack[m_ch] = 1'b1; m_data = m_word;
          m_last = m_ch; m_pending = 1'b0; m_quiet = 1'b1;
        end else if (m_stall < 65535) begin
          m_stall++;
        end
      end else if (m_quiet) begin
        m_quiet = 1'b0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!m_pending && done[c] && !channel_mask[c]) begin
            m_pending = 1'b1; m_ch = c;
            m_word.chan_id = CHAN_ID_W'(c);
            m_word.adc = dout[c*ADCBITS +: ADCBITS];
            m_word.ts = timestamp;
          end
        end
      end
    end
  endtask

  task automatic compare_outputs();
    chk("wr_en", 64'(fifo_wr_en), 64'(m_wr));
    chk("ack", 64'(ack), 64'(m_ack));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
    if (m_wr) chk("wr_data", 64'(fifo_wr_data), 64'(m_data));
  endtask

  // One clock: model and DUT advance on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
    if (fifo_wr_en) begin
      wlog_ch.push_back(int'(fifo_wr_data[DW-1 -: CHAN_ID_W]));
      wlog_cyc.push_back(cyc);
    end
    if (auto_clear) done = done & ~ack;
    cyc++;
    timestamp = timestamp + 24'd1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_data", 64'(fifo_wr_data), 64'd0);
    chk("rst_stall", 64'(stall_count), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    wlog_ch.delete();
    wlog_cyc.delete();
  endtask

  task automatic wait_write(input string tag, input int max_cycles);
    int s;
    bit seen;
    s = wlog_ch.size();
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      step();
      if (wlog_ch.size() > s) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single channel: latency and exact word contents.
    done[5] = 1'b1;
    dout[5*ADCBITS +: ADCBITS] = 10'h155;
    timestamp = 24'h000100;
    step();
    chk("lat_edge1_wr", 64'(fifo_wr_en), 64'd0);
    step();
    chk("lat_edge2_wr", 64'(fifo_wr_en), 64'd1);
    chk("lat_word", 64'(fifo_wr_data), 64'h15_5500_0100);
    chk("lat_ack5", 64'(ack), 64'(64'd1 << 5));
    step();
    step();

    // All channels requesting continuously: strict rotation, one word per 3 cycles.
    do_reset();
    auto_clear = 1'b0;
    done = '1;
    for (int i = 0; i < 200; i++) step();
    chk("rr_count", 64'(wlog_ch.size() >= 65), 64'd1);
    if (wlog_ch.size() >= 65) begin
      for (int i = 0; i < 65; i++) chk("rr_order", 64'(wlog_ch[i]), 64'(i % N));
      for (int i = 1; i < 65; i++) chk("rr_spacing", 64'(wlog_cyc[i] - wlog_cyc[i-1]), 64'd3);
    end
    auto_clear = 1'b1;
    done = '0;

    // Wrap-around after last grant 59.
    do_reset();
    done[59] = 1'b1;
    wait_write("wrap_w59", 10);
    wlog_ch.delete();
    done[3] = 1'b1;
    done[60] = 1'b1;
    wait_write("wrap_w1", 10);
    wait_write("wrap_w2", 10);
    if (wlog_ch.size() >= 2) begin
      chk("wrap_first", 64'(wlog_ch[0]), 64'd60);
      chk("wrap_second", 64'(wlog_ch[1]), 64'd3);
    end

    // FIFO full stalls a captured word for 10 cycles.
    do_reset();
    fifo_full = 1'b1;
    done[7] = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk("stall_nowrite", 64'(wlog_ch.size()), 64'd0);
    chk("stall_10", 64'(stall_count), 64'd10);
    fifo_full = 1'b0;
    step();
    chk("stall_release_wr", 64'(fifo_wr_en), 64'd1);
    chk("stall_release_ch", 64'(fifo_wr_data[DW-1 -: CHAN_ID_W]), 64'd7);
    step();

    // Masked channel is never granted until unmasked.
    do_reset();
    channel_mask[9] = 1'b1;
    done[9] = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("mask_nogrant", 64'(wlog_ch.size()), 64'd0);
    channel_mask[9] = 1'b0;
    wait_write("unmask_w", 10);
    if (wlog_ch.size() >= 1) chk("unmask_ch", 64'(wlog_ch[0]), 64'd9);

    // Reset while a word is pending discards it; priority restarts at channel 0.
    do_reset();
    done[20] = 1'b1;
    step();
    do_reset();
    chk("rst_issue_nowrite", 64'(wlog_ch.size()), 64'd0);
    done[0] = 1'b1;
    wait_write("post_rst_w1", 10);
    wait_write("post_rst_w2", 10);
    if (wlog_ch.size() >= 2) begin
      chk("post_rst_first", 64'(wlog_ch[0]), 64'd0);
      chk("post_rst_second", 64'(wlog_ch[1]), 64'd20);
    end

    // Random traffic against the reference model.
    do_reset();
    done = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) done[$urandom_range(0, N-1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) channel_mask[$urandom_range(0, N-1)] ^= 1'b1;
      fifo_full = ($urandom_range(0, 9) < 3);
      for (int c = 0; c < N; c++) dout[c*ADCBITS +: ADCBITS] = ADCBITS'($urandom_range(0, 1023));
      step();
    end
    chk("random_progress", 64'(wlog_ch.size() > 50), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
